mult_32bit_seq: RTL and testbench

//  Multi-cycle shift-add multiplier for MULT/MULTU; 32x32 -> 64-bit {hi,lo}.

---
 rtl/mult_32bit_seq_pkg.sv | 22 ++
 rtl/mult_32bit_seq_adder.sv | 20 ++
 rtl/mult_32bit_seq.sv | 135 +++++++++++++
 tb/tb_mult_32bit_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mult_32bit_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential multiplier.
// Signed support is compiled in with SIGNED_MULT_EN.
package mult_32bit_seq_pkg;

   localparam int WORD_W    = 32;
   localparam int MULT_ITER = 32;
   localparam int CNT_W     = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // -2^31 maps to 2^31, which is still a valid unsigned magnitude.
   function automatic logic [WORD_W-1:0] abs_w(
      input logic [WORD_W-1:0] v
   );
      return v[WORD_W-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/mult_32bit_seq_adder.sv
// 32-bit ripple-style adder used for the per-iteration accumulate.
// Provides carry out and signed overflow.
module mult_32bit_seq_adder
   import mult_32bit_seq_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              carry_out,
   output logic              overflow
);

   assign {carry_out, sum} = {1'b0, a} + {1'b0, b}
                           + {{WORD_W{1'b0}}, cin};

   assign overflow = (a[WORD_W-1] == b[WORD_W-1])
                  && (sum[WORD_W-1] != a[WORD_W-1]);

endmodule

// File: rtl/mult_32bit_seq.sv
// Multi-cycle shift-add multiplier, 32x32 -> {hi,lo}, fixed 32 iterations.
// Define SIGNED_MULT_EN to honour signed_op (magnitude multiply + sign fix).
module mult_32bit_seq
   import mult_32bit_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        signed_op,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MULT_ITER - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [WORD_W-1:0]      m_q, m_d;
   logic [2*WORD_W-1:0]    p_q, p_d;
   logic                   neg_q, neg_d;
   logic [WORD_W-1:0]      hi_q, hi_d;
   logic [WORD_W-1:0]      lo_q, lo_d;

   logic [WORD_W-1:0]      add_sum;
   logic                   add_c;
   logic                   ovf_unused;
   logic [2*WORD_W-1:0]    p_step;
   logic [2*WORD_W-1:0]    prod_fix;

   mult_32bit_seq_adder u_add (
      .a         (p_q[2*WORD_W-1:WORD_W]),
      .b         (m_q),
      .cin       (1'b0),
      .sum       (add_sum),
      .carry_out (add_c),
      .overflow  (ovf_unused)
   );

`ifndef SIGNED_MULT_EN
   logic sign_unused;
   assign sign_unused = signed_op;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      m_d     = m_q;
      p_d     = p_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      // The adder carry becomes the new top bit of the shifted product.
      if (p_q[0]) begin
         p_step = {add_c, add_sum, p_q[WORD_W-1:1]};
      end else begin
         p_step = {1'b0, p_q[2*WORD_W-1:WORD_W],
                   p_q[WORD_W-1:1]};
      end
      prod_fix = neg_q ? (~p_step + 64'd1) : p_step;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CALC;
               count_d = '0;
`ifdef SIGNED_MULT_EN
               if (signed_op) begin
                  m_d   = abs_w(multiplicand);
                  p_d   = {{WORD_W{1'b0}},
                           abs_w(multiplier)};
                  neg_d = multiplicand[WORD_W-1]
                        ^ multiplier[WORD_W-1];
               end else begin
                  m_d   = multiplicand;
                  p_d   = {{WORD_W{1'b0}}, multiplier};
                  neg_d = 1'b0;
               end
`else
               m_d   = multiplicand;
               p_d   = {{WORD_W{1'b0}}, multiplier};
               neg_d = 1'b0;
`endif
            end
         end
         ST_CALC: begin
            p_d = p_step;
            if (count_q == LAST) begin
               count_d = '0;
               hi_d    = prod_fix[2*WORD_W-1:WORD_W];
               lo_d    = prod_fix[WORD_W-1:0];
               state_d = ST_DONE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         m_q     <= '0;
         p_q     <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         m_q     <= m_d;
         p_q     <= p_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_32bit_seq.sv
// Self-checking bench for mult_32bit_seq: cycle model plus directed vectors.
// Honours SIGNED_MULT_EN the same way the design does.
module tb_mult_32bit_seq;

`ifdef SIGNED_MULT_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        start;
   logic        signed_op;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   mult_32bit_seq dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .signed_op    (signed_op),
      .multiplicand (a_i),
      .multiplier   (b_i),
      .busy         (busy),
      .done         (done),
      .hi           (hi),
      .lo           (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_prod(
      input logic [31:0] x,
      input logic [31:0] y,
      input logic        s
   );
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      if (SIGNED_EN && s) return 64'(sx * sy);
      return {32'b0, x} * {32'b0, y};
   endfunction

   // Model: -1 idle, else edges since accept; result lands after 32 edges.
   int          m_cnt  = -1;
   logic [31:0] m_hi   = '0;
   logic [31:0] m_lo   = '0;
   logic [63:0] m_pend = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt <= -1;
         m_hi  <= '0;
         m_lo  <= '0;
      end else if (m_cnt < 0) begin
         if (start) begin
            m_cnt  <= 0;
            m_pend <= ref_prod(a_i, b_i, signed_op);
         end
      end else begin
         if (m_cnt == 31) {m_hi, m_lo} <= m_pend;
         m_cnt <= (m_cnt == 32) ? -1 : m_cnt + 1;
      end
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("busy", 64'(busy), 64'(m_cnt >= 0));
      chk("done", 64'(done), 64'(m_cnt == 32));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
   endtask

   task automatic run_op(input logic [31:0] x,
                         input logic [31:0] y,
                         input logic        s,
                         input logic [31:0] ehi,
                         input logic [31:0] elo,
                         input string       nm);
      int n;
      a_i = x; b_i = y; signed_op = s; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk({nm, "_latency"}, 64'(n), 64'd32);
      chk({nm, "_hi"}, 64'(hi), 64'(ehi));
      chk({nm, "_lo"}, 64'(lo), 64'(elo));
      tick();
   endtask

   initial begin
      int dones;
      reset = 1'b1; start = 1'b0; signed_op = 1'b0;
      a_i = '0; b_i = '0;
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      tick();
      reset = 1'b0;
      tick();

      run_op(32'd7, 32'd6, 1'b0, 32'h0, 32'h2A, "7x6");
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
             32'hFFFFFFFE, 32'h1, "ffxff");

      // Start during CALC must be ignored.
      a_i = 32'd3; b_i = 32'd4; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      a_i = 32'd9; b_i = 32'd9; start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0;
      repeat (45) begin
         tick();
         if (done) dones++;
      end
      chk("ovl_dones", 64'(dones), 64'd1);
      chk("ovl_hi", 64'(hi), 64'h0);
      chk("ovl_lo", 64'(lo), 64'hC);

      // Asynchronous reset mid-operation.
      a_i = 32'd5; b_i = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_hi", 64'(hi), 64'd0);
      chk("arst_lo", 64'(lo), 64'd0);
      tick();
      reset = 1'b0;
      dones = 0;
      repeat (40) begin
         tick();
         if (done) dones++;
      end
      chk("arst_nodone", 64'(dones), 64'd0);
      run_op(32'd5, 32'd5, 1'b0, 32'h0, 32'h19, "5x5");

`ifdef SIGNED_MULT_EN
      run_op(32'hFFFFFFFD, 32'd5, 1'b1,
             32'hFFFFFFFF, 32'hFFFFFFF1, "sneg");
`else
      run_op(32'hFFFFFFFD, 32'd5, 1'b1,
             32'h00000004, 32'hFFFFFFF1, "sneg");
`endif
      run_op(32'h80000000, 32'h80000000, 1'b1,
             32'h40000000, 32'h0, "smin");

      // Start held high: each IDLE sample begins a new op.
      a_i = 32'd3; b_i = 32'd7; signed_op = 1'b0;
      start = 1'b1;
      dones = 0;
      repeat (75) begin
         tick();
         if (done) dones++;
      end
      start = 1'b0;
      repeat (40) tick();
      chk("hold_dones", 64'(dones), 64'd2);
      chk("hold_lo", 64'(lo), 64'd21);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
